// File: rtl/fft16_twiddle_mult.sv
// Twiddle multiplier between radix-4 FFT16 stages: drives the twiddle ROM address,
// multiplies each streamed sample by W16^k, then rounds, saturates and tags frame markers.
module fft16_twiddle_mult #(
  parameter int DW        = 16,
  parameter int TW        = 18,
  parameter int BYPASS_W0 = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic [3:0]           rom_addr,
  input  logic [TW-1:0]        rom_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 sat_flag,
  output logic                 sop_err
);

  localparam int HW   = TW / 2;
  localparam int PW   = DW + HW;
  localparam int SW   = DW + HW + 1;
  localparam int FRAC = HW - 1;

  localparam logic signed [SW-1:0] RND_VAL = SW'(1 << (FRAC - 1));
  localparam logic signed [SW-1:0] MAX_VAL = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_VAL = -SW'(1 << (DW - 1));

  // Sample counter and ROM address
  logic [3:0] cnt_reg;
  logic       accept_sop;

  assign accept_sop = in_valid && in_sop;
  assign rom_addr   = accept_sop ? 4'd0 : cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 4'd0;
      sop_err <= 1'b0;
    end else begin
      sop_err <= accept_sop && (cnt_reg != 4'd0);
      if (in_valid) begin
        cnt_reg <= rom_addr + 4'd1;
      end
    end
  end

  // Stage 1: input sample captured; ROM word for the same sample is available this stage
  logic                 s1_valid, s1_sop, s1_eop, s1_bypass;
  logic signed [DW-1:0] s1_re, s1_im;
  logic                 trivial_tw;

  assign trivial_tw = (BYPASS_W0 != 0) && ((rom_addr[3:2] == 2'd0) || (rom_addr[1:0] == 2'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      s1_bypass <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s1_sop    <= in_valid && (rom_addr == 4'd0);
      s1_eop    <= in_valid && (rom_addr == 4'd15);
      s1_bypass <= in_valid && trivial_tw;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_re <= in_re;
      s1_im <= in_im;
    end
  end

  // Stage 2: four partial products
  logic signed [HW-1:0] tw_re, tw_im;
  logic signed [PW-1:0] a_ext, b_ext, c_ext, d_ext;
  logic signed [PW-1:0] s2_ac, s2_bd, s2_ad, s2_bc;
  logic signed [DW-1:0] s2_re, s2_im;
  logic                 s2_valid, s2_sop, s2_eop, s2_bypass;

  assign tw_re = rom_data[TW-1:HW];
  assign tw_im = rom_data[HW-1:0];
  assign a_ext = PW'(s1_re);
  assign b_ext = PW'(s1_im);
  assign c_ext = PW'(tw_re);
  assign d_ext = PW'(tw_im);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_sop    <= 1'b0;
      s2_eop    <= 1'b0;
      s2_bypass <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      s2_sop    <= s1_sop;
      s2_eop    <= s1_eop;
      s2_bypass <= s1_bypass;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_ac <= a_ext * c_ext;
      s2_bd <= b_ext * d_ext;
      s2_ad <= a_ext * d_ext;
      s2_bc <= b_ext * c_ext;
      s2_re <= s1_re;
      s2_im <= s1_im;
    end
  end

  // Stage 3: combine, round half up, clamp to the output range
  logic signed [SW-1:0] sum_val [2];
  logic signed [DW-1:0] res_val [2];
  logic                 clamp   [2];

  assign sum_val[0] = SW'(s2_ac) - SW'(s2_bd);
  assign sum_val[1] = SW'(s2_ad) + SW'(s2_bc);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_round_sat
      logic signed [SW-1:0] rounded;
      logic signed [SW-1:0] shifted;
      logic                 over_hi, over_lo;

      assign rounded = sum_val[gi] + RND_VAL;
      assign shifted = rounded >>> FRAC;
      assign over_hi = shifted > MAX_VAL;
      assign over_lo = shifted < MIN_VAL;
      assign clamp[gi]   = over_hi || over_lo;
      assign res_val[gi] = over_hi ? MAX_VAL[DW-1:0] :
                           over_lo ? MIN_VAL[DW-1:0] : shifted[DW-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      sat_flag  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= s2_valid;
      out_sop   <= s2_valid && s2_sop;
      out_eop   <= s2_valid && s2_eop;
      sat_flag  <= s2_valid && !s2_bypass && (clamp[0] || clamp[1]);
      if (s2_valid) begin
        out_re <= s2_bypass ? s2_re : res_val[0];
        out_im <= s2_bypass ? s2_im : res_val[1];
      end
    end
  end

endmodule

// File: tb/tb_fft16_twiddle_mult.sv
// Directed bench for fft16_twiddle_mult: ROM model, hand-computed frame results,
// saturation, gaps, early sop and mid-stream reset, checked with immediate assertions.
module tb_fft16_twiddle_mult;

  localparam int DW  = 16;
  localparam int TW  = 18;
  localparam int BYP = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_sop = 1'b0;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic [3:0]           rom_addr;
  logic [TW-1:0]        rom_data;
  logic                 out_valid, out_sop, out_eop, sat_flag, sop_err;
  logic signed [DW-1:0] out_re, out_im;

  fft16_twiddle_mult #(.DW(DW), .TW(TW), .BYPASS_W0(BYP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_re(in_re), .in_im(in_im), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_re(out_re), .out_im(out_im), .sat_flag(sat_flag), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  // Twiddle W16^k with k = addr[3:2]*addr[1:0], Q1.8 truncated
  function automatic logic [17:0] tw_word(input logic [3:0] a);
    logic signed [8:0] c, d;
    int k;
    k = int'(a[3:2]) * int'(a[1:0]);
    case (k)
      0:       begin c = 9'sd255;  d = 9'sd0;    end
      1:       begin c = 9'sd235;  d = -9'sd97;  end
      2:       begin c = 9'sd180;  d = -9'sd180; end
      3:       begin c = 9'sd97;   d = -9'sd235; end
      4:       begin c = 9'sd0;    d = -9'sd255; end
      6:       begin c = -9'sd180; d = -9'sd180; end
      9:       begin c = -9'sd235; d = 9'sd97;   end
      default: begin c = 9'sd0;    d = 9'sd0;    end
    endcase
    return {c, d};
  endfunction

  always @(posedge clk) rom_data <= tw_word(rom_addr);

  function automatic int rnd_sat(input int x, output bit s);
    int r;
    r = (x + 128) >>> 8;
    s = 1'b0;
    if (r > 32767) begin r = 32767; s = 1'b1; end
    if (r < -32768) begin r = -32768; s = 1'b1; end
    return r;
  endfunction

  task automatic model(input int a, input int b, input logic [3:0] ad,
                       output int ore, output int oim, output bit sat);
    logic [17:0] w;
    logic signed [8:0] cs, ds;
    int c, d;
    bit s1, s2;
    if (BYP != 0 && (ad[3:2] == 2'd0 || ad[1:0] == 2'd0)) begin
      ore = a; oim = b; sat = 1'b0;
    end else begin
      w = tw_word(ad);
      cs = w[17:9]; ds = w[8:0];
      c = cs; d = ds;
      ore = rnd_sat(a * c - b * d, s1);
      oim = rnd_sat(a * d + b * c, s2);
      sat = s1 | s2;
    end
  endtask

  typedef struct {
    bit v, sop, eop, sat;
    int re, im;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         step_no = 0;
  logic [3:0] bcnt = 4'd0;
  int         last_re = 0;
  int         last_im = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @step %0d: observed %0d expected %0d", tag, step_no, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_out(input exp_t e);
    if (e.v) begin
      last_re = e.re;
      last_im = e.im;
    end
    chk("out_valid", 32'(out_valid), 32'(e.v));
    chk("out_sop",   32'(out_sop),   32'(e.sop));
    chk("out_eop",   32'(out_eop),   32'(e.eop));
    chk("sat_flag",  32'(sat_flag),  32'(e.sat));
    chk("out_re",    32'(out_re),    32'(last_re));
    chk("out_im",    32'(out_im),    32'(last_im));
  endtask

  // One clock of stimulus; optional hand-computed result overrides the model
  task automatic step(input bit v, input bit s, input int re, input int im,
                      input bit hand = 1'b0, input int hre = 0, input int him = 0,
                      input bit hsat = 1'b0);
    logic [3:0] addr;
    bit         exp_err;
    exp_t       e;
    in_valid = v; in_sop = s; in_re = DW'(re); in_im = DW'(im);
    addr = (v && s) ? 4'd0 : bcnt;
    #1 chk("rom_addr", 32'(rom_addr), 32'(addr));
    e.v = v;
    e.sop = v && (addr == 4'd0);
    e.eop = v && (addr == 4'd15);
    model(re, im, addr, e.re, e.im, e.sat);
    if (hand) begin e.re = hre; e.im = him; e.sat = hsat; end
    if (!v) e.sat = 1'b0;
    exp_err = v && s && (bcnt != 4'd0);
    if (v) bcnt = addr + 4'd1;
    q.push_back(e);
    @(posedge clk); #1;
    step_no++;
    chk("sop_err", 32'(sop_err), 32'(exp_err));
    if (q.size() == 3) check_out(q.pop_front());
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  int f1_re [16] = '{1000, 1000, 1000, 1000, 1000, 918, 703, 379,
                     1000, 703, 0, -703, 1000, 379, -703, -918};
  int f1_im [16] = '{0, 0, 0, 0, 0, -379, -703, -918,
                     0, -703, -996, -703, 0, -918, -703, 379};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_re",    32'(out_re),    32'd0);
    chk("rst_out_im",    32'(out_im),    32'd0);
    chk("rst_rom_addr",  32'(rom_addr),  32'd0);
    chk("rst_sop_err",   32'(sop_err),   32'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Frame of (1000,0) with hand-computed products
    for (int i = 0; i < 16; i++) step(1, i == 0, 1000, 0, 1'b1, f1_re[i], f1_im[i], 1'b0);

    // Back-to-back frame of random data ending in a saturating sample at addr 15
    for (int i = 0; i < 15; i++) step(1, i == 0, rnd16(), rnd16());
    step(1, 0, -32768, -32768, 1'b1, 32767, 17664, 1'b1);

    // Gaps in in_valid
    for (int i = 0; i < 12; i++) step((i % 3) != 1 && (i % 3) != 2 || i > 8, i == 0, rnd16(), rnd16());
    step(0, 0, 0, 0);

    // Early sop with six samples already in the frame
    for (int i = 0; i < 6; i++) step(1, i == 0, rnd16(), rnd16());
    step(1, 1, rnd16(), rnd16());
    for (int i = 0; i < 6; i++) step(1, 0, rnd16(), rnd16());

    // Mid-stream reset discards in-flight samples
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_re",    32'(out_re),    32'd0);
    chk("mid_rst_out_im",    32'(out_im),    32'd0);
    in_valid = 1'b0; in_sop = 1'b0;
    #1 chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    bcnt = 4'd0; last_re = 0; last_im = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Short frame after reset, then drain
    for (int i = 0; i < 8; i++) step(1, i == 0, rnd16(), rnd16());
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
